// File: rtl/image_scan_sequencer_pkg.sv
// Shared types and default geometry for the image scan sequencer.
package image_scan_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN  = 3'd1,
    GAP   = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } scan_state_t;

  localparam int unsigned DEF_COL_BITS = 4;
  localparam int unsigned DEF_ROW_BITS = 4;
  localparam int unsigned DEF_LINE_GAP = 2;

endpackage

// File: rtl/image_scan_sequencer_if.sv
// Control strobes in, pixel address stream and status out.
interface image_scan_sequencer_if
  import image_scan_sequencer_pkg::*;
#(
  parameter int unsigned COL_BITS = DEF_COL_BITS,
  parameter int unsigned ROW_BITS = DEF_ROW_BITS
);
  logic                start_strobe;
  logic                pause_strobe;
  logic                abort;
  logic                pixel_ready;
  logic [COL_BITS-1:0] col;
  logic [ROW_BITS-1:0] row;
  logic                pixel_valid;
  logic                line_end;
  logic                frame_done;
  logic                busy;

  // Sequencer side: drives the pixel stream.
  modport master (
    input  start_strobe, pause_strobe, abort, pixel_ready,
    output col, row, pixel_valid, line_end, frame_done, busy
  );

  // Controller / consumer side.
  modport slave (
    output start_strobe, pause_strobe, abort, pixel_ready,
    input  col, row, pixel_valid, line_end, frame_done, busy
  );
endinterface

// File: rtl/image_scan_sequencer_counter.sv
// Generic up-counter with enable, synchronous clear and wrap at a runtime max.
module image_scan_sequencer_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic [W-1:0] i_max,
  output logic [W-1:0] o_cnt,
  output logic         o_at_max_c
);
  logic [W-1:0] r_cnt;

  assign o_cnt      = r_cnt;
  assign o_at_max_c = (r_cnt == i_max);

  // Clear wins over count; counting past max wraps to zero.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_at_max_c ? '0 : r_cnt + W'(1);
    end
  end
endmodule

// File: rtl/image_scan_sequencer.sv
// Start/pause/abort controlled raster scan of a 2^COL_BITS x 2^ROW_BITS frame.
module image_scan_sequencer
  import image_scan_sequencer_pkg::*;
#(
  parameter int unsigned COL_BITS = DEF_COL_BITS,
  parameter int unsigned ROW_BITS = DEF_ROW_BITS,
  parameter int unsigned LINE_GAP = DEF_LINE_GAP
) (
  input  logic                   clk,
  input  logic                   nrst,
  image_scan_sequencer_if.master bus
);
  localparam int unsigned GAP_W   = (LINE_GAP > 1) ? $clog2(LINE_GAP) : 1;
  localparam int unsigned GAP_MAX = (LINE_GAP == 0) ? 0 : LINE_GAP - 1;
  localparam bit          HAS_GAP = (LINE_GAP != 0);

  scan_state_t         r_state;
  logic [COL_BITS-1:0] w_col;
  logic [ROW_BITS-1:0] w_row;
  logic [GAP_W-1:0]    w_gap;
  logic                w_col_max;
  logic                w_row_max;
  logic                w_gap_max;
  logic                w_valid;
  logic                w_hs;
  logic                w_last;
  logic                w_in_gap;
  logic                w_in_done;

  assign w_valid   = (r_state == SCAN);
  assign w_in_gap  = (r_state == GAP);
  assign w_in_done = (r_state == DONE);
  assign w_hs      = w_valid & bus.pixel_ready;
  assign w_last    = w_hs & w_col_max & w_row_max;

  // Column advances on every handshake except the final pixel, where it holds at max.
  image_scan_sequencer_counter #(.W(COL_BITS)) u_col (
    .clk        (clk),
    .nrst       (nrst),
    .i_en       (w_hs & ~(w_col_max & w_row_max)),
    .i_clr      (bus.abort | w_in_done),
    .i_max      ({COL_BITS{1'b1}}),
    .o_cnt      (w_col),
    .o_at_max_c (w_col_max)
  );

  // Row advances at the end of the gap, or directly on the column wrap when there is no gap.
  image_scan_sequencer_counter #(.W(ROW_BITS)) u_row (
    .clk        (clk),
    .nrst       (nrst),
    .i_en       ((w_in_gap & w_gap_max) |
                 (!HAS_GAP & w_hs & w_col_max & ~w_row_max)),
    .i_clr      (bus.abort | w_in_done),
    .i_max      ({ROW_BITS{1'b1}}),
    .o_cnt      (w_row),
    .o_at_max_c (w_row_max)
  );

  // Gap counter sits at zero outside GAP so each gap starts from a fresh count.
  image_scan_sequencer_counter #(.W(GAP_W)) u_gap (
    .clk        (clk),
    .nrst       (nrst),
    .i_en       (w_in_gap),
    .i_clr      (bus.abort | ~w_in_gap),
    .i_max      (GAP_W'(GAP_MAX)),
    .o_cnt      (w_gap),
    .o_at_max_c (w_gap_max)
  );

  // Frame state machine; abort dominates, end-of-row/frame beats a coincident pause.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= IDLE;
    end else if (bus.abort) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE:    if (bus.start_strobe) r_state <= SCAN;
        SCAN: begin
          if (w_last)                             r_state <= DONE;
          else if (w_hs && w_col_max && HAS_GAP)  r_state <= GAP;
          else if (bus.pause_strobe)              r_state <= PAUSE;
        end
        GAP:     if (w_gap_max) r_state <= SCAN;
        PAUSE:   if (bus.pause_strobe || bus.start_strobe) r_state <= SCAN;
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.col         = w_col;
  assign bus.row         = w_row;
  assign bus.pixel_valid = w_valid;
  assign bus.line_end    = w_hs & w_col_max;
  assign bus.frame_done  = w_in_done;
  assign bus.busy        = (r_state != IDLE);

  logic w_unused;
  assign w_unused = ^w_gap;
endmodule

// File: tb/tb_image_scan_sequencer.sv
// Directed self-checking bench for image_scan_sequencer (default and LINE_GAP=0 builds).
module tb_image_scan_sequencer;
  logic clk;
  logic nrst;
  int   vectors;
  int   fails;

  image_scan_sequencer_if #(.COL_BITS(4), .ROW_BITS(4)) bus ();
  image_scan_sequencer_if #(.COL_BITS(4), .ROW_BITS(4)) bus2 ();

  image_scan_sequencer #(.COL_BITS(4), .ROW_BITS(4), .LINE_GAP(2)) dut (
    .clk (clk), .nrst (nrst), .bus (bus)
  );

  image_scan_sequencer #(.COL_BITS(4), .ROW_BITS(4), .LINE_GAP(0)) dut0 (
    .clk (clk), .nrst (nrst), .bus (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Hold pixel_ready high until (c,r) is presented on the default DUT.
  task automatic run_to(input int c, input int r, input string tag);
    int i;
    bus.pixel_ready = 1'b1;
    i = 0;
    while (!(bus.pixel_valid && bus.col == 4'(c) && bus.row == 4'(r)) && i < 400) begin
      tick();
      i++;
    end
    chk(tag, 32'(i < 400), 32'd1);
  endtask

  // Start a frame on the default DUT and follow it until busy drops.
  task automatic run_frame(input bit toggle, output int cycles, output int le,
                           output int gaps, output int fds, output int fd_k,
                           output int hs, output int seq_err);
    int k, ec, er;
    k = 0; ec = 0; er = 0; le = 0; gaps = 0; fds = 0; fd_k = -1; hs = 0; seq_err = 0;
    bus.start_strobe = 1'b1;
    tick();
    bus.start_strobe = 1'b0;
    while (bus.busy && k < 2000) begin
      bus.pixel_ready = toggle ? (k % 2 == 0) : 1'b1;
      le += int'(bus.line_end);
      if (bus.pixel_valid) begin
        if (bus.col !== 4'(ec) || bus.row !== 4'(er)) seq_err++;
        if (bus.pixel_ready) begin
          hs++;
          if (ec == 15) begin ec = 0; er++; end else ec++;
        end
      end else if (!bus.frame_done) begin
        gaps++;
      end
      if (bus.frame_done) begin fds++; fd_k = k; end
      tick();
      k++;
    end
    cycles = k;
  endtask

  initial begin
    int cyc, le, gaps, fds, fd_k, hs, seq_err, k, ec, er;
    bit fd_seen;
    vectors = 0;
    fails   = 0;
    nrst = 1'b0;
    bus.start_strobe = 0;  bus.pause_strobe = 0;  bus.abort = 0;  bus.pixel_ready = 0;
    bus2.start_strobe = 0; bus2.pause_strobe = 0; bus2.abort = 0; bus2.pixel_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy",  32'(bus.busy), 0);
    chk("reset valid", 32'(bus.pixel_valid), 0);
    chk("reset col",   32'(bus.col), 0);
    chk("reset row",   32'(bus.row), 0);
    chk("reset done",  32'(bus.frame_done), 0);
    nrst = 1'b1;
    tick();
    bus.pause_strobe = 1'b1;
    tick();
    bus.pause_strobe = 1'b0;
    chk("pause in idle ignored", 32'(bus.busy), 0);

    // Full frame with ready held high.
    run_frame(1'b0, cyc, le, gaps, fds, fd_k, hs, seq_err);
    chk("frame busy cycles", 32'(cyc), 287);
    chk("frame line_end count", 32'(le), 16);
    chk("frame gap cycles", 32'(gaps), 30);
    chk("frame done count", 32'(fds), 1);
    chk("frame done position", 32'(fd_k), 286);
    chk("frame handshakes", 32'(hs), 256);
    chk("frame address order", 32'(seq_err), 0);
    chk("frame end idle col", 32'(bus.col), 0);
    chk("frame end idle row", 32'(bus.row), 0);

    // Ready toggling every cycle.
    run_frame(1'b1, cyc, le, gaps, fds, fd_k, hs, seq_err);
    chk("toggle handshakes", 32'(hs), 256);
    chk("toggle address order", 32'(seq_err), 0);
    chk("toggle line_end count", 32'(le), 16);
    chk("toggle done count", 32'(fds), 1);
    chk("toggle ends idle", 32'(bus.busy), 0);

    // Pause without handshake at (5,3).
    bus.start_strobe = 1'b1;
    tick();
    bus.start_strobe = 1'b0;
    chk("start col", 32'(bus.col), 0);
    chk("start valid", 32'(bus.pixel_valid), 1);
    run_to(5, 3, "reach 5,3");
    bus.pixel_ready = 1'b0;
    bus.pause_strobe = 1'b1;
    tick();
    bus.pause_strobe = 1'b0;
    chk("pause valid", 32'(bus.pixel_valid), 0);
    chk("pause busy", 32'(bus.busy), 1);
    repeat (10) tick();
    chk("paused col", 32'(bus.col), 5);
    chk("paused row", 32'(bus.row), 3);
    bus.start_strobe = 1'b1;
    tick();
    bus.start_strobe = 1'b0;
    chk("resume valid", 32'(bus.pixel_valid), 1);
    chk("resume col", 32'(bus.col), 5);
    chk("resume row", 32'(bus.row), 3);

    // Pause coincident with handshake at (5,3).
    bus.pixel_ready = 1'b1;
    bus.pause_strobe = 1'b1;
    tick();
    bus.pause_strobe = 1'b0;
    chk("pause+hs valid", 32'(bus.pixel_valid), 0);
    chk("pause+hs col", 32'(bus.col), 6);
    chk("pause+hs row", 32'(bus.row), 3);
    bus.pause_strobe = 1'b1;
    tick();
    bus.pause_strobe = 1'b0;
    chk("pause toggles back", 32'(bus.pixel_valid), 1);

    // Abort with pause at (9,7).
    run_to(9, 7, "reach 9,7");
    bus.abort = 1'b1;
    bus.pause_strobe = 1'b1;
    tick();
    bus.abort = 1'b0;
    bus.pause_strobe = 1'b0;
    fd_seen = bus.frame_done;
    chk("abort busy", 32'(bus.busy), 0);
    chk("abort col", 32'(bus.col), 0);
    chk("abort row", 32'(bus.row), 0);
    repeat (3) begin
      tick();
      fd_seen |= bus.frame_done;
    end
    chk("abort no frame_done", 32'(fd_seen), 0);
    bus.start_strobe = 1'b1;
    tick();
    bus.start_strobe = 1'b0;
    chk("restart valid", 32'(bus.pixel_valid), 1);
    chk("restart col", 32'(bus.col), 0);

    // Spurious start during SCAN.
    run_to(2, 0, "reach 2,0");
    bus.start_strobe = 1'b1;
    tick();
    bus.start_strobe = 1'b0;
    chk("spurious start col", 32'(bus.col), 3);
    chk("spurious start row", 32'(bus.row), 0);

    // Reset asserted while in GAP.
    run_to(15, 0, "reach 15,0");
    chk("line_end at col max", 32'(bus.line_end), 1);
    tick();
    chk("gap valid", 32'(bus.pixel_valid), 0);
    chk("gap busy", 32'(bus.busy), 1);
    #2;
    nrst = 1'b0;
    #1;
    chk("async reset busy", 32'(bus.busy), 0);
    chk("async reset col", 32'(bus.col), 0);
    chk("async reset row", 32'(bus.row), 0);
    chk("async reset line_end", 32'(bus.line_end), 0);
    chk("async reset done", 32'(bus.frame_done), 0);
    tick();
    nrst = 1'b1;
    bus.pixel_ready = 1'b0;
    tick();

    // LINE_GAP=0 build: no gap cycles, row steps on the column wrap.
    bus2.start_strobe = 1'b1;
    bus2.pixel_ready  = 1'b1;
    tick();
    bus2.start_strobe = 1'b0;
    k = 0; ec = 0; er = 0; gaps = 0; seq_err = 0; hs = 0; fds = 0;
    while (bus2.busy && k < 2000) begin
      if (bus2.pixel_valid) begin
        if (bus2.col !== 4'(ec) || bus2.row !== 4'(er)) seq_err++;
        hs++;
        if (ec == 15) begin ec = 0; er++; end else ec++;
      end else if (!bus2.frame_done) begin
        gaps++;
      end
      if (bus2.frame_done) fds++;
      tick();
      k++;
    end
    chk("nogap busy cycles", 32'(k), 257);
    chk("nogap gap cycles", 32'(gaps), 0);
    chk("nogap address order", 32'(seq_err), 0);
    chk("nogap handshakes", 32'(hs), 256);
    chk("nogap done count", 32'(fds), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
